// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller and its environment
// (buttons, target switches, BCD digit datapath).
interface stopwatch_ctrl_if;
    logic        i_start;
    logic        i_stop;
    logic        i_clear;
    logic [5:0]  i_target;
    logic [19:0] i_time;
    logic        o_cnt_en;
    logic        o_cnt_clr;
    logic        o_running;
    logic        o_done;
    logic        o_ovf;
    logic [1:0]  o_state;

    // Environment side: drives the controls and digits, observes the controller.
    modport master (
        output i_start, i_stop, i_clear, i_target, i_time,
        input  o_cnt_en, o_cnt_clr, o_running, o_done, o_ovf, o_state
    );

    // Controller side.
    modport slave (
        input  i_start, i_stop, i_clear, i_target, i_time,
        output o_cnt_en, o_cnt_clr, o_running, o_done, o_ovf, o_state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronizes and edge-detects start/stop/clear,
// divides the system clock into tenth-second count enables, and stops at a
// switch-selected target second or at the 59:59.9 maximum.
// Note: i_rst_n is an asynchronous ACTIVE-HIGH reset; the _n suffix is kept
// only for naming consistency with the rest of the codebase.
module stopwatch_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    stopwatch_ctrl_if.slave bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Bit positions inside the conditioned control vectors.
    localparam int CI_START = 0;
    localparam int CI_STOP  = 1;
    localparam int CI_CLEAR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       sync_d [SYNC_STAGES];
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       pulse_q, pulse_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, div_adv;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             tgt_en, match, at_max;
    logic             start_p, stop_p, clear_p;

    assign start_p = pulse_q[CI_START];
    assign stop_p  = pulse_q[CI_STOP];
    assign clear_p = pulse_q[CI_CLEAR];

    // Synchronizer shift and rising-edge detection of the three controls.
    always_comb begin
        sync_d[0] = {bus.i_clear, bus.i_stop, bus.i_start};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Synchronizer, edge-history and one-cycle pulse registers.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b000;
            end
            prev_q  <= 3'b000;
            pulse_q <= 3'b000;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    // Target / maximum comparison against the fed-back digits {m1,m0,s1,s0,ml}.
    // The tens-of-seconds field is only 2 bits wide, so its <=5 bound always holds.
    always_comb begin
        tgt_en = (bus.i_target != 6'h00) && (bus.i_target[3:0] <= 4'd9);
        match  = tgt_en
              && (bus.i_time[11:8] == {2'b00, bus.i_target[5:4]})
              && (bus.i_time[7:4]  == bus.i_target[3:0])
              && (bus.i_time[3:0]  == 4'h0);
        at_max = (bus.i_time == 20'h59599);
    end

    // Next-state, divider and output decode; priority clear > stop > start > match > max.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        ovf_d     = ovf_q;
        cnt_clr_d = 1'b0;
        div_adv   = (div_q == DIV_LAST) ? DIV_ZERO : (div_q + DIV_ONE);
        case (state_q)
            ST_IDLE: begin
                if (clear_p) begin
                    cnt_clr_d = 1'b1;
                    div_d     = DIV_ZERO;
                end else if (start_p) begin
                    state_d = ST_RUN;
                    div_d   = DIV_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear_p) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                    div_d     = DIV_ZERO;
                end else if (stop_p) begin
                    // The stop cycle still counts toward the partial tenth.
                    state_d = ST_PAUSE;
                    div_d   = div_adv;
                end else if (match) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b0;
                end else if (at_max) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b1;
                end else begin
                    div_d = div_adv;
                end
            end
            ST_PAUSE: begin
                if (clear_p) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                    div_d     = DIV_ZERO;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (clear_p) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                    ovf_d     = 1'b0;
                    div_d     = DIV_ZERO;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = DIV_ZERO;
                ovf_d   = 1'b0;
            end
        endcase
        // Registered enable: look ahead at next cycle's stop/clear pulses so the
        // enable is suppressed in the cycle those transitions are taken. Match and
        // max only become true the cycle after an increment (divider at 0), which
        // can never coincide with DIV-1 because DIV >= 2.
        cnt_en_d  = (state_d == ST_RUN) && (div_d == DIV_LAST)
                 && !pulse_d[CI_STOP] && !pulse_d[CI_CLEAR];
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State, divider and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_ZERO;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            running_q <= running_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_cnt_en  = cnt_en_q;
    assign bus.o_cnt_clr = cnt_clr_q;
    assign bus.o_running = running_q;
    assign bus.o_done    = done_q;
    assign bus.o_ovf     = ovf_q;
    assign bus.o_state   = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed stimulus pushes hand-timed
// expected events (state changes, clear pulses, count enables); a monitor pops
// and compares every event the DUT presents. A BCD datapath model feeds i_time.
module tb_stopwatch_ctrl;
    localparam int CLK_HZ      = 20;
    localparam int TICK_HZ     = 2;
    localparam int SYNC_STAGES = 2;
    localparam int EV_ST  = 0;
    localparam int EV_CLR = 1;
    localparam int EV_EN  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] st;
        logic       run;
        logic       done;
        logic       ovf;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] tm = 20'h00000;
    logic        load_req = 1'b0;
    logic [19:0] load_val = 20'h00000;
    logic [1:0]  mon_prev_st = 2'b00;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    ev_t         exp_q[$];

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(
        .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst),
        .bus(bus)
    );

    assign bus.i_time = tm;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] bcd_inc(input logic [19:0] t);
        logic [3:0] m1, m0, s1, s0, ml;
        {m1, m0, s1, s0, ml} = t;
        if (ml != 4'd9) ml = ml + 4'd1;
        else begin
            ml = 4'd0;
            if (s0 != 4'd9) s0 = s0 + 4'd1;
            else begin
                s0 = 4'd0;
                if (s1 != 4'd5) s1 = s1 + 4'd1;
                else begin
                    s1 = 4'd0;
                    if (m0 != 4'd9) m0 = m0 + 4'd1;
                    else begin
                        m0 = 4'd0;
                        m1 = (m1 != 4'd5) ? m1 + 4'd1 : 4'd0;
                    end
                end
            end
        end
        return {m1, m0, s1, s0, ml};
    endfunction

    // Datapath model: digits clear on o_cnt_clr, advance on o_cnt_en.
    always @(posedge clk) begin
        if (load_req) tm <= load_val;
        else if (bus.o_cnt_clr) tm <= 20'h00000;
        else if (bus.o_cnt_en) tm <= bcd_inc(tm);
    end

    function automatic string kname(input int k);
        case (k)
            EV_ST:   return "state";
            EV_CLR:  return "cnt_clr";
            EV_EN:   return "cnt_en";
            default: return "unknown";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c, input logic [1:0] st, input logic ovf);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.st   = st;
        e.run  = (st == 2'b01);
        e.done = (st == 2'b11);
        e.ovf  = ovf;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: got event at cycle %0d (state=%b run=%b done=%b ovf=%b), expected none",
                     kname(kind), cyc, bus.o_state, bus.o_running, bus.o_done, bus.o_ovf);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc &&
                (kind != EV_ST || (bus.o_state === e.st && bus.o_running === e.run &&
                                   bus.o_done === e.done && bus.o_ovf === e.ovf)))
                n_pass++;
            else
                $display("FAIL event_%s: got %s at cycle %0d (state=%b run=%b done=%b ovf=%b), expected %s at cycle %0d (state=%b run=%b done=%b ovf=%b)",
                         kname(e.kind), kname(kind), cyc, bus.o_state, bus.o_running, bus.o_done, bus.o_ovf,
                         kname(e.kind), e.cyc, e.st, e.run, e.done, e.ovf);
        end
    endtask

    // Monitor: every presented output event is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_state !== mon_prev_st) begin
                observe(EV_ST);
                mon_prev_st = bus.o_state;
            end
            if (bus.o_cnt_clr === 1'b1) observe(EV_CLR);
            if (bus.o_cnt_en === 1'b1) observe(EV_EN);
        end
    end

    task automatic check_val(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_state"},   bus.o_state,                2'b00);
        check_val({tag, "_cnt_en"},  {1'b0, bus.o_cnt_en},       2'b00);
        check_val({tag, "_cnt_clr"}, {1'b0, bus.o_cnt_clr},      2'b00);
        check_val({tag, "_running"}, {1'b0, bus.o_running},      2'b00);
        check_val({tag, "_done"},    {1'b0, bus.o_done},         2'b00);
        check_val({tag, "_ovf"},     {1'b0, bus.o_ovf},          2'b00);
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) wait_edge();
    endtask

    // Watchdog: the directed sequence ends in a few hundred cycles.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus; a level set just after edge n is first sampled at
    // edge n+1, so its state change appears in cycle n+4.
    initial begin
        int n, p, s, r2, r3, r4, c;
        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_stop   = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_target = 6'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_outputs_zero("reset");

        // Start from IDLE: RUN after 4 edges, enables in RUN cycles 10, 20, 30.
        wait_edge();
        n = cyc;
        bus.i_start = 1'b1;
        push_ev(EV_ST, n + 4, 2'b01, 1'b0);
        push_ev(EV_EN, n + 13, 2'b00, 1'b0);
        push_ev(EV_EN, n + 23, 2'b00, 1'b0);
        push_ev(EV_EN, n + 33, 2'b00, 1'b0);
        p = n + 33;

        // Stop taken 4 cycles after the pulse: divider held at 4.
        wait_until(p + 1);
        bus.i_stop  = 1'b1;
        bus.i_start = 1'b0;
        push_ev(EV_ST, p + 5, 2'b10, 1'b0);

        // 50 PAUSE cycles, then resume: first enable in the 6th RUN cycle.
        wait_until(p + 51);
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b0;
        s = p + 55;
        push_ev(EV_ST, s, 2'b01, 1'b0);
        push_ev(EV_EN, s + 5, 2'b00, 1'b0);

        // Stop+clear landing on an enable cycle: clear wins, enable suppressed.
        wait_until(s + 12);
        bus.i_stop  = 1'b1;
        bus.i_clear = 1'b1;
        bus.i_start = 1'b0;
        push_ev(EV_ST, s + 16, 2'b00, 1'b0);
        push_ev(EV_CLR, s + 16, 2'b00, 1'b0);

        // Target 12 s, digits preset to 00:11.9.
        wait_until(s + 20);
        bus.i_stop   = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_target = 6'h12;
        load_val     = 20'h00119;
        load_req     = 1'b1;
        wait_edge();
        load_req     = 1'b0;
        bus.i_start  = 1'b1;
        r2 = cyc + 4;
        push_ev(EV_ST, r2, 2'b01, 1'b0);
        push_ev(EV_EN, r2 + 9, 2'b00, 1'b0);
        push_ev(EV_ST, r2 + 11, 2'b11, 1'b0);

        // Clear out of DONE.
        wait_until(r2 + 20);
        bus.i_start = 1'b0;
        wait_until(r2 + 25);
        bus.i_clear = 1'b1;
        push_ev(EV_ST, r2 + 29, 2'b00, 1'b0);
        push_ev(EV_CLR, r2 + 29, 2'b00, 1'b0);

        // Overflow: target disabled, digits preset to 59:59.8.
        wait_until(r2 + 32);
        bus.i_clear  = 1'b0;
        bus.i_target = 6'h3F;
        load_val     = 20'h59598;
        load_req     = 1'b1;
        wait_edge();
        load_req     = 1'b0;
        bus.i_start  = 1'b1;
        r3 = cyc + 4;
        push_ev(EV_ST, r3, 2'b01, 1'b0);
        push_ev(EV_EN, r3 + 9, 2'b00, 1'b0);
        push_ev(EV_ST, r3 + 11, 2'b11, 1'b1);

        // A fresh start edge in DONE is ignored (no event expected).
        wait_until(r3 + 15);
        bus.i_start = 1'b0;
        wait_until(r3 + 20);
        bus.i_start = 1'b1;

        // Clear from overflow DONE drops o_ovf.
        wait_until(r3 + 30);
        bus.i_clear = 1'b1;
        push_ev(EV_ST, r3 + 34, 2'b00, 1'b0);
        push_ev(EV_CLR, r3 + 34, 2'b00, 1'b0);

        wait_until(r3 + 38);
        bus.i_clear = 1'b0;
        bus.i_start = 1'b0;
        wait_until(r3 + 42);
        bus.i_start = 1'b1;
        r4 = r3 + 46;
        push_ev(EV_ST, r4, 2'b01, 1'b0);

        // Asynchronous reset between edges, in the cycle of the first enable.
        wait_until(r4 + 9);
        check_val("en_before_rst", {1'b0, bus.o_cnt_en}, 2'b01);
        push_ev(EV_ST, r4 + 9, 2'b00, 1'b0);
        #1 rst = 1'b1;
        #1 check_outputs_zero("async_rst");
        wait_edge();
        wait_edge();
        c = cyc;
        #1 rst = 1'b0;
        // i_start still high: exactly one RUN entry after release.
        push_ev(EV_ST, c + 4, 2'b01, 1'b0);
        push_ev(EV_EN, c + 13, 2'b00, 1'b0);
        wait_until(c + 16);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover_events: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch counter datapath. It synchronizes and edge-detects the start, stop and clear controls and divides the system clock into tenth-second count enables. It stops counting when the displayed time reaches a switch-selected target or the 59:59.9 maximum. The datapath's BCD digit counters advance only on this block's `o_cnt_en` and clear on `o_cnt_clr`. The datapath feeds its packed digits back for comparison.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 10: count-enable rate. `DIV = CLK_HZ/TICK_HZ`; `DIV` must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer depth on `i_start`, `i_stop`, `i_clear`.
- `i_clk` (in, 1): system clock; all state updates on the rising edge.
- `i_rst_n` (in, 1): asynchronous, active-high reset. The `_n` suffix is kept for codebase naming consistency; 1 means reset.
- `i_start` (in, 1): asynchronous level; a rising edge requests run or resume.
- `i_stop` (in, 1): asynchronous level; a rising edge requests pause.
- `i_clear` (in, 1): asynchronous level; a rising edge requests clear to zero.
- `i_target` (in, 6): `[5:4]` target tens-of-seconds (BCD), `[3:0]` target units-of-seconds (BCD).
- `i_time` (in, 20): datapath digits `{m1,m0,s1,s0,ml}`, 4-bit BCD each.
- `o_cnt_en` (out, 1): one-cycle datapath increment enable.
- `o_cnt_clr` (out, 1): one-cycle datapath clear.
- `o_running` (out, 1): high while in RUN.
- `o_done` (out, 1): high while in DONE.
- `o_ovf` (out, 1): high in DONE when DONE was reached by maximum time rather than by target.
- `o_state` (out, 2): IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Input conditioning:
  - Each control input passes through a `SYNC_STAGES` flop synchronizer, then a registered rising-edge detector.
  - This gives one pulse per low-to-high transition. A held level never repeats the pulse.
- Target enable:
  - The target is enabled when `i_target != 6'h00`, `i_target[5:4] <= 5` and `i_target[3:0] <= 9`.
  - Any other value disables target compare.
- Match condition: target enabled && `s1 == {2'b0, i_target[5:4]}` && `s0 == i_target[3:0]` && `ml == 0`. The minute digits are ignored.
- Max condition: `i_time == 20'h59599`.
- Event priority when several requests coincide in one cycle: clear > stop > start > match > max.
- State transitions:
  - IDLE:
    - clear → stay in IDLE and pulse `o_cnt_clr`.
    - start → RUN, with the divider zeroed.
    - stop → ignored.
  - RUN:
    - clear → IDLE and pulse `o_cnt_clr`.
    - stop → PAUSE, with the divider value held.
    - match → DONE with `o_ovf` = 0.
    - max → DONE with `o_ovf` = 1.
    - start → ignored.
  - PAUSE:
    - clear → IDLE and pulse `o_cnt_clr`.
    - start → RUN; the divider resumes from its held value, preserving the partial tenth.
    - stop → ignored.
  - DONE:
    - clear → IDLE, pulse `o_cnt_clr`, and `o_ovf` → 0.
    - start and stop → ignored.
- Divider:
  - The divider counts 0..`DIV-1` only in RUN and wraps to 0.
  - `o_cnt_en` = 1 for exactly the cycle in which state is RUN and the divider equals `DIV-1`.
  - In RUN, the match and max conditions are evaluated every cycle.
  - In the cycle a stop, clear, match or max transition is taken, `o_cnt_en` is forced to 0.
- Datapath wrap: the datapath never wraps past 59:59.9, because max forces DONE.

## Timing
- Reset values: state IDLE; `o_cnt_en`, `o_cnt_clr`, `o_running`, `o_done`, `o_ovf` all 0; `o_state` = 00. The divider, synchronizers and edge registers reset to 0.
- An input level held high through reset produces one edge after release.
- Control latency: an input rising edge first sampled at clock edge k produces a state change at edge k+`SYNC_STAGES`+1, with outputs updated the same edge.
- All outputs are registered and no output has a combinational path from any input.
- `o_cnt_clr` is high for the single cycle immediately following the clear-accepting edge, coinciding with the first IDLE cycle.
- Count timing from IDLE:
  - The first `o_cnt_en` is high in the `DIV`-th cycle of RUN.
  - Subsequent pulses are exactly `DIV` cycles apart.
- Match and max reaction:
  - The datapath updates `i_time` on the edge that samples `o_cnt_en`.
  - The FSM enters DONE on the next edge.
  - Because `DIV` ≥ 2, no extra increment is issued.
- A match already true on entering RUN forces DONE one cycle later, with zero increments.
- Reset mid-RUN: the block enters IDLE immediately and asynchronously and drops `o_cnt_en` the same instant. No `o_cnt_clr` pulse is issued.

## Test plan
All scenarios use `CLK_HZ`=20, `TICK_HZ`=2, `DIV`=10, `SYNC_STAGES`=2.
- Reset then start:
  - Stimulus: `i_start` rises, first sampled at edge 0.
  - Required: `o_state` = 01 after edge 3; `o_cnt_en` pulses in RUN cycles 10, 20 and 30; `o_cnt_en` is never high for two consecutive cycles.
- Pause and resume:
  - Stimulus: stop applied 4 cycles after an `o_cnt_en` pulse; hold PAUSE for 50 cycles; apply start.
  - Required: no `o_cnt_en` during PAUSE; the first post-resume pulse comes 6 RUN cycles after re-entry.
- Target:
  - Stimulus: `i_target` = 6'h12; the bench model feeds `i_time` 00:11.9 → 00:12.0.
  - Required: DONE on the next edge with `o_done` = 1 and `o_ovf` = 0; no further `o_cnt_en`.
- Overflow:
  - Stimulus: `i_target` = 6'h3F (disabled); `i_time` reaches 20'h59599.
  - Required: DONE with `o_ovf` = 1; a subsequent start is ignored.
- Simultaneous stop+clear in RUN:
  - Required: IDLE, exactly one `o_cnt_clr` pulse, and no `o_cnt_en` in that cycle.
- Asynchronous reset asserted mid-RUN between clock edges:
  - Required: outputs go to 0 and `o_state` = 00 before the next edge.
  - After release with `i_start` held high, RUN is entered once.
